// File: rtl/sensor_bus_arbiter.sv
// Arbitrates the shared SCLK/SDAT pin pair between the SPI and I2C masters,
// with idle guard intervals around every hand-over and forced eviction of a hung owner.
module sensor_bus_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_req,
  input  logic spi_done,
  input  logic spi_sclk,
  input  logic spi_sdat_out,
  input  logic spi_sdat_oe,
  input  logic i2c_req,
  input  logic i2c_done,
  input  logic i2c_scl,
  input  logic i2c_sda_out,
  input  logic i2c_sda_oe,
  input  logic err_clr,
  output logic spi_gnt,
  output logic i2c_gnt,
  output logic pin_sclk,
  output logic pin_sdat_out,
  output logic pin_sdat_oe,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    SPI_OWN,
    I2C_OWN,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES - 1);
  // Release interval is one cycle longer than the pre-grant guard so the
  // gap from gnt fall to the next gnt rise is 2*GUARD_CYCLES+2.
  localparam logic [CNT_W-1:0] COOL_LD  = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pend_spi, pend_spi_nx;
  logic             last_spi, last_spi_nx;
  logic             timeout_err_nx;

  logic own_spi, own_req, own_done, pend_req;

  assign own_spi  = (state == SPI_OWN);
  assign own_req  = own_spi ? spi_req  : i2c_req;
  assign own_done = own_spi ? spi_done : i2c_done;
  assign pend_req = pend_spi ? spi_req : i2c_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_spi    <= 1'b0;
      last_spi    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pend_spi    <= pend_spi_nx;
      last_spi    <= last_spi_nx;
      timeout_err <= timeout_err_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    pend_spi_nx    = pend_spi;
    last_spi_nx    = last_spi;
    timeout_err_nx = timeout_err & ~err_clr;

    case (state)
      IDLE: begin
        if (spi_req || i2c_req) begin
          // On a tie the requester that did not own the pins last wins.
          pend_spi_nx = spi_req && (!i2c_req || !last_spi);
          cnt_nx      = GUARD_LD;
          state_nx    = GUARD;
        end
      end
      GUARD: begin
        if (!pend_req) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = pend_spi ? SPI_OWN : I2C_OWN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - ONE;
        end
      end
      SPI_OWN, I2C_OWN: begin
        if (own_done || !own_req || cnt == TO_LAST) begin
          if (!own_done && own_req) timeout_err_nx = 1'b1;
          last_spi_nx = own_spi;
          cnt_nx      = COOL_LD;
          state_nx    = RELEASE;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      RELEASE: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - ONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    spi_gnt      = (state == SPI_OWN);
    i2c_gnt      = (state == I2C_OWN);
    pin_sclk     = 1'b1;
    pin_sdat_out = 1'b1;
    pin_sdat_oe  = 1'b0;
    case (state)
      SPI_OWN: begin
        pin_sclk     = spi_sclk;
        pin_sdat_out = spi_sdat_out;
        pin_sdat_oe  = spi_sdat_oe;
      end
      I2C_OWN: begin
        pin_sclk     = i2c_scl;
        pin_sdat_out = i2c_sda_out;
        pin_sdat_oe  = i2c_sda_oe;
      end
      default: ;
    endcase
  end

endmodule
